// File: rtl/flash_cmd_pkg.sv
// rtl/flash_cmd_pkg.sv - flash command bytes, status bits, error codes and FSM encoding
//
// Purpose: shared constants for the flash record store and its bus master.
// Ports:   none (package).
package flash_cmd_pkg;

   // Intel-style command bytes
   localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
   localparam logic [7:0] CMD_ERASE      = 8'h20;
   localparam logic [7:0] CMD_CONFIRM    = 8'hD0;
   localparam logic [7:0] CMD_PROGRAM    = 8'h40;
   localparam logic [7:0] CMD_CLR_SR     = 8'h50;

   // Status register bit positions
   localparam int SR_READY     = 7;
   localparam int SR_ERASE_ERR = 5;
   localparam int SR_PROG_ERR  = 4;
   localparam int SR_VPP_ERR   = 3;

   // err_code values
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ERASE   = 2'd1;
   localparam logic [1:0] ERR_PROG    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Sequencer states
   localparam logic [3:0] ST_IDLE        = 4'd0;
   localparam logic [3:0] ST_ERASE_SETUP = 4'd1;
   localparam logic [3:0] ST_ERASE_CONF  = 4'd2;
   localparam logic [3:0] ST_ERASE_POLL  = 4'd3;
   localparam logic [3:0] ST_PROG_SETUP  = 4'd4;
   localparam logic [3:0] ST_PROG_DATA   = 4'd5;
   localparam logic [3:0] ST_PROG_POLL   = 4'd6;
   localparam logic [3:0] ST_READ_ARRAY  = 4'd7;
   localparam logic [3:0] ST_LOAD_READ   = 4'd8;
   localparam logic [3:0] ST_CLR_STATUS  = 4'd9;
   localparam logic [3:0] ST_FINISH      = 4'd10;

   // A status byte reports "done" once the ready bit is set
   function automatic logic sr_ready(input logic [7:0] sr);
      return sr[SR_READY];
   endfunction

endpackage

// File: rtl/flash_bus_master.sv
// rtl/flash_bus_master.sv - turns single op requests into one fb_start pulse with held address/data
//
// Purpose: issues one bridge access per accepted op_req, holds fb_addr/fb_wdata/fb_dir
//          from the fb_start cycle until fb_done, and reports completion.
// Ports:
//   CLK_50MHZ, RST          clock, synchronous active-high reset
//   op_req                  request one access (accepted only when none outstanding)
//   op_dir/op_addr/op_wdata access direction (1 = read), address, write byte
//   op_done                 completion of the outstanding access (fb_done qualified)
//   op_rdata                read byte, valid with op_done
//   fb_addr/fb_wdata/fb_dir bridge request fields
//   fb_start                1-cycle start pulse
//   fb_rdata/fb_done        bridge response
module flash_bus_master
   import flash_cmd_pkg::*;
#(
   parameter logic [7:0] RESET_ADDR = 8'h00
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic       op_req,
   input  logic       op_dir,
   input  logic [7:0] op_addr,
   input  logic [7:0] op_wdata,
   output logic       op_done,
   output logic [7:0] op_rdata,
   output logic [7:0] fb_addr,
   output logic [7:0] fb_wdata,
   output logic       fb_dir,
   output logic       fb_start,
   input  logic [7:0] fb_rdata,
   input  logic       fb_done
);

   logic pending;

   // fb_done only counts when an access is actually open
   assign op_done  = pending && fb_done;
   assign op_rdata = fb_rdata;

   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         pending  <= 1'b0;
         fb_start <= 1'b0;
         fb_dir   <= 1'b1;
         fb_addr  <= RESET_ADDR;
         fb_wdata <= CMD_READ_ARRAY;
      end else begin
         fb_start <= 1'b0;
         if (op_req && !pending) begin
            pending  <= 1'b1;
            fb_start <= 1'b1;
            fb_dir   <= op_dir;
            fb_addr  <= op_addr;
            fb_wdata <= op_wdata;
         end else if (op_done) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/flash_record_store.sv
// rtl/flash_record_store.sv - saves/loads a scoreboard record to/from NOR flash over the 8-bit bridge
//
// Purpose: save = block erase + byte program of REC_LEN bytes with status polling, then read-array;
//          load = read-array then REC_LEN byte reads written back to the record.
// Ports:
//   CLK_50MHZ, RST             clock, synchronous active-high reset
//   save_req, load_req         1-cycle request pulses (save wins; ignored while busy)
//   busy, done, err, err_code  operation status; err/err_code valid with done
//   rec_idx, rec_rdata         record byte index and its current value
//   rec_we, rec_wdata          record write strobe and byte during load
//   fb_addr, fb_wdata, fb_dir, fb_start, fb_rdata, fb_done  flash bridge handshake
module flash_record_store
   import flash_cmd_pkg::*;
#(
   parameter int          REC_LEN   = 4,
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter logic [15:0] POLL_MAX  = 16'd60000
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic       save_req,
   input  logic       load_req,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] rec_idx,
   input  logic [7:0] rec_rdata,
   output logic       rec_we,
   output logic [7:0] rec_wdata,
   output logic [7:0] fb_addr,
   output logic [7:0] fb_wdata,
   input  logic [7:0] fb_rdata,
   output logic       fb_dir,
   output logic       fb_start,
   input  logic       fb_done
);

   localparam logic [7:0]  LAST_IDX   = 8'(REC_LEN - 1);
   localparam logic [16:0] POLL_LIMIT = {1'b0, POLL_MAX};

   logic [3:0]  state;
   logic        issued;     // the current state's access has been handed to the bus master
   logic        mode_load;
   logic [7:0]  idx;
   logic [15:0] poll_cnt;
   logic        err_flag;
   logic [16:0] poll_next;

   logic        op_req;
   logic        op_dir;
   logic [7:0]  op_addr;
   logic [7:0]  op_wdata;
   logic        op_done;
   logic [7:0]  op_rdata;
   logic [7:0]  byte_addr;

   // 8-bit wrap of the record address is intentional
   assign byte_addr = BASE_ADDR + idx;
   assign poll_next = {1'b0, poll_cnt} + 17'd1;

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FINISH);
   assign err       = err_flag;
   assign rec_idx   = idx;
   assign rec_we    = op_done && (state == ST_LOAD_READ);
   assign rec_wdata = rec_we ? op_rdata : 8'h00;

   // Every state except IDLE/FINISH performs exactly one access per visit (polls re-arm 'issued')
   always_comb begin
      op_req   = 1'b0;
      op_dir   = 1'b1;
      op_addr  = BASE_ADDR;
      op_wdata = CMD_READ_ARRAY;
      case (state)
         ST_ERASE_SETUP: begin op_req = !issued; op_dir = 1'b0; op_wdata = CMD_ERASE;   end
         ST_ERASE_CONF:  begin op_req = !issued; op_dir = 1'b0; op_wdata = CMD_CONFIRM; end
         ST_ERASE_POLL:  begin op_req = !issued; end
         ST_PROG_SETUP:  begin op_req = !issued; op_dir = 1'b0; op_addr = byte_addr; op_wdata = CMD_PROGRAM; end
         ST_PROG_DATA:   begin op_req = !issued; op_dir = 1'b0; op_addr = byte_addr; op_wdata = rec_rdata;   end
         ST_PROG_POLL:   begin op_req = !issued; op_addr = byte_addr; end
         ST_READ_ARRAY:  begin op_req = !issued; op_dir = 1'b0; op_wdata = CMD_READ_ARRAY; end
         ST_LOAD_READ:   begin op_req = !issued; op_addr = byte_addr; end
         ST_CLR_STATUS:  begin op_req = !issued; op_dir = 1'b0; op_wdata = CMD_CLR_SR; end
         default:        begin op_req = 1'b0; end
      endcase
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         state     <= ST_IDLE;
         issued    <= 1'b0;
         mode_load <= 1'b0;
         idx       <= 8'h00;
         poll_cnt  <= 16'h0000;
         err_flag  <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         if (op_req) issued <= 1'b1;
         case (state)
            ST_IDLE: begin
               issued   <= 1'b0;
               idx      <= 8'h00;
               poll_cnt <= 16'h0000;
               if (save_req) begin
                  mode_load <= 1'b0;
                  err_flag  <= 1'b0;
                  err_code  <= ERR_NONE;
                  state     <= ST_ERASE_SETUP;
               end else if (load_req) begin
                  mode_load <= 1'b1;
                  err_flag  <= 1'b0;
                  err_code  <= ERR_NONE;
                  state     <= ST_READ_ARRAY;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default: begin
               if (op_done) begin
                  issued <= 1'b0;
                  case (state)
                     ST_ERASE_SETUP: state <= ST_ERASE_CONF;
                     ST_ERASE_CONF: begin
                        poll_cnt <= 16'h0000;
                        state    <= ST_ERASE_POLL;
                     end
                     ST_ERASE_POLL: begin
                        if (sr_ready(op_rdata)) begin
                           if (op_rdata[SR_ERASE_ERR]) begin
                              err_flag <= 1'b1;
                              err_code <= ERR_ERASE;
                              state    <= ST_CLR_STATUS;
                           end else begin
                              idx   <= 8'h00;
                              state <= ST_PROG_SETUP;
                           end
                        end else if (poll_next >= POLL_LIMIT) begin
                           err_flag <= 1'b1;
                           err_code <= ERR_TIMEOUT;
                           state    <= ST_CLR_STATUS;
                        end else begin
                           poll_cnt <= poll_next[15:0];
                        end
                     end
                     ST_PROG_SETUP: state <= ST_PROG_DATA;
                     ST_PROG_DATA: begin
                        poll_cnt <= 16'h0000;
                        state    <= ST_PROG_POLL;
                     end
                     ST_PROG_POLL: begin
                        if (sr_ready(op_rdata)) begin
                           if (op_rdata[SR_PROG_ERR] || op_rdata[SR_VPP_ERR]) begin
                              err_flag <= 1'b1;
                              err_code <= ERR_PROG;
                              state    <= ST_CLR_STATUS;
                           end else if (idx == LAST_IDX) begin
                              state <= ST_READ_ARRAY;
                           end else begin
                              idx   <= idx + 8'd1;
                              state <= ST_PROG_SETUP;
                           end
                        end else if (poll_next >= POLL_LIMIT) begin
                           err_flag <= 1'b1;
                           err_code <= ERR_TIMEOUT;
                           state    <= ST_CLR_STATUS;
                        end else begin
                           poll_cnt <= poll_next[15:0];
                        end
                     end
                     ST_CLR_STATUS: state <= ST_READ_ARRAY;
                     ST_READ_ARRAY: begin
                        idx   <= 8'h00;
                        state <= (mode_load && !err_flag) ? ST_LOAD_READ : ST_FINISH;
                     end
                     ST_LOAD_READ: begin
                        if (idx == LAST_IDX) state <= ST_FINISH;
                        else                 idx   <= idx + 8'd1;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   flash_bus_master #(
      .RESET_ADDR (BASE_ADDR)
   ) u_bus (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .op_req    (op_req),
      .op_dir    (op_dir),
      .op_addr   (op_addr),
      .op_wdata  (op_wdata),
      .op_done   (op_done),
      .op_rdata  (op_rdata),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .fb_dir    (fb_dir),
      .fb_start  (fb_start),
      .fb_rdata  (fb_rdata),
      .fb_done   (fb_done)
   );

endmodule

// File: tb/tb_flash_record_store.sv
// tb/tb_flash_record_store.sv - bench for flash_record_store with a bridge+flash model
module tb_flash_record_store;

   localparam logic [7:0]  BASE = 8'hFE;
   localparam logic [15:0] PMAX = 16'd5;

   logic       CLK_50MHZ = 1'b0;
   logic       RST;
   logic       save_req, load_req;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic [7:0] rec_idx, rec_rdata, rec_wdata;
   logic       rec_we;
   logic [7:0] fb_addr, fb_wdata, fb_rdata;
   logic       fb_dir, fb_start, fb_done;

   always #10 CLK_50MHZ = ~CLK_50MHZ;

   logic [7:0] record [4];
   assign rec_rdata = record[rec_idx[1:0]];

   flash_record_store #(.REC_LEN(4), .BASE_ADDR(BASE), .POLL_MAX(PMAX)) dut (
      .CLK_50MHZ(CLK_50MHZ), .RST(RST), .save_req(save_req), .load_req(load_req),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .rec_idx(rec_idx), .rec_rdata(rec_rdata), .rec_we(rec_we), .rec_wdata(rec_wdata),
      .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .fb_dir(fb_dir),
      .fb_start(fb_start), .fb_done(fb_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- bridge + flash model ----------------
   logic [7:0]  mem [256];
   bit          st_mode, exp_conf, exp_prog, pend, spurious, never_ready;
   int          pend_cnt, polls_left, busy_polls, prog_count, fail_prog_n;
   logic [7:0]  sr_err;
   logic        cur_dir;
   logic [7:0]  cur_addr, cur_wdata;
   logic [16:0] bus_log[$];
   logic [16:0] exp_log[$];
   logic [15:0] we_log[$];
   int          done_cnt = 0;
   logic        last_err;
   logic [1:0]  last_code;

   initial begin
      fb_done = 1'b0; fb_rdata = 8'h00; pend = 0;
      forever begin
         @(posedge CLK_50MHZ); #1;
         fb_done = 1'b0;
         if (RST) begin
            pend = 0;
         end else if (pend) begin
            check("bus_hold", {15'd0, fb_dir, fb_addr, fb_wdata}, {15'd0, cur_dir, cur_addr, cur_wdata});
            check("start_while_open", {31'd0, fb_start}, 32'd0);
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend = 0;
               fb_done = 1'b1;
               if (cur_dir) begin
                  if (st_mode) begin
                     if (never_ready || polls_left > 0) begin
                        if (polls_left > 0) polls_left--;
                        fb_rdata = 8'h00;
                     end else fb_rdata = 8'h80 | sr_err;
                  end else fb_rdata = mem[cur_addr];
               end else begin
                  fb_rdata = $urandom;
                  if (exp_conf) begin
                     exp_conf = 0;
                     if (cur_wdata == 8'hD0) begin
                        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
                        polls_left = busy_polls; sr_err = 8'h00; st_mode = 1;
                     end
                  end else if (exp_prog) begin
                     exp_prog = 0;
                     mem[cur_addr] = mem[cur_addr] & cur_wdata;
                     prog_count++;
                     polls_left = busy_polls;
                     sr_err = (prog_count == fail_prog_n) ? 8'h10 : 8'h00;
                     st_mode = 1;
                  end else begin
                     case (cur_wdata)
                        8'h20: exp_conf = 1;
                        8'h40: exp_prog = 1;
                        8'h50: sr_err = 8'h00;
                        8'hFF: st_mode = 0;
                        default: ;
                     endcase
                  end
               end
            end
         end else if (fb_start) begin
            cur_dir = fb_dir; cur_addr = fb_addr; cur_wdata = fb_wdata;
            bus_log.push_back({fb_dir, fb_addr, fb_dir ? 8'h00 : fb_wdata});
            pend = 1;
            pend_cnt = $urandom_range(3, 10);
         end else if (spurious) begin
            spurious = 0;
            fb_done = 1'b1;
            fb_rdata = 8'h80;
         end
      end
   end

   // Completion and record-write monitor (sampled after fb_done settles)
   initial begin
      forever begin
         @(posedge CLK_50MHZ); #2;
         if (!RST && done) begin
            done_cnt++; last_err = err; last_code = err_code;
         end
         if (!RST && rec_we) we_log.push_back({rec_idx, rec_wdata});
      end
   end

   // ---------------- expected-sequence builders ----------------
   function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
      return {1'b0, a, d};
   endfunction
   function automatic logic [16:0] rd(input logic [7:0] a);
      return {1'b1, a, 8'h00};
   endfunction

   task automatic build_save(input int p, input int fail_at, input bit tmo);
      logic [7:0] a;
      exp_log.delete();
      exp_log.push_back(wr(BASE, 8'h20));
      exp_log.push_back(wr(BASE, 8'hD0));
      if (tmo) begin
         repeat (int'(PMAX)) exp_log.push_back(rd(BASE));
         exp_log.push_back(wr(BASE, 8'h50));
         exp_log.push_back(wr(BASE, 8'hFF));
         return;
      end
      repeat (p + 1) exp_log.push_back(rd(BASE));
      for (int i = 0; i < 4; i++) begin
         a = BASE + 8'(i);
         exp_log.push_back(wr(a, 8'h40));
         exp_log.push_back(wr(a, record[i]));
         repeat (p + 1) exp_log.push_back(rd(a));
         if (i + 1 == fail_at) begin
            exp_log.push_back(wr(BASE, 8'h50));
            exp_log.push_back(wr(BASE, 8'hFF));
            return;
         end
      end
      exp_log.push_back(wr(BASE, 8'hFF));
   endtask

   task automatic build_load();
      exp_log.delete();
      exp_log.push_back(wr(BASE, 8'hFF));
      for (int i = 0; i < 4; i++) exp_log.push_back(rd(BASE + 8'(i)));
   endtask

   task automatic compare_log(input string tag);
      int n;
      check({tag, "_len"}, bus_log.size(), exp_log.size());
      n = (bus_log.size() < exp_log.size()) ? bus_log.size() : exp_log.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), {15'd0, bus_log[i]}, {15'd0, exp_log[i]});
   endtask

   task automatic wait_done(input string tag, input int start);
      int k = 0;
      while (done_cnt == start && k < 5000) begin
         @(posedge CLK_50MHZ); #1; k++;
      end
      check({tag, "_done"}, done_cnt, start + 1);
      @(posedge CLK_50MHZ); #1;
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_save(input string tag, input int p, input int fail_at, input bit tmo,
                           input logic [1:0] code);
      int start = done_cnt;
      bus_log.delete(); we_log.delete();
      busy_polls = p;
      save_req = 1; @(posedge CLK_50MHZ); #1; save_req = 0;
      wait_done(tag, start);
      check({tag, "_err"}, {31'd0, last_err}, {31'd0, (code != 2'd0)});
      check({tag, "_code"}, {30'd0, last_code}, {30'd0, code});
      check({tag, "_no_we"}, we_log.size(), 0);
      build_save(p, fail_at, tmo);
      compare_log(tag);
   endtask

   task automatic run_load(input string tag);
      int start = done_cnt;
      bus_log.delete(); we_log.delete();
      load_req = 1; @(posedge CLK_50MHZ); #1; load_req = 0;
      wait_done(tag, start);
      check({tag, "_err"}, {31'd0, last_err}, 32'd0);
      check({tag, "_we_cnt"}, we_log.size(), 4);
      for (int i = 0; i < 4 && i < we_log.size(); i++)
         check($sformatf("%s_we[%0d]", tag, i), {16'd0, we_log[i]}, {16'd0, 8'(i), record[i]});
      build_load();
      compare_log(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  {31'd0, busy},  32'd0);
      check({tag, "_done"},  {31'd0, done},  32'd0);
      check({tag, "_err"},   {31'd0, err},   32'd0);
      check({tag, "_code"},  {30'd0, err_code}, 32'd0);
      check({tag, "_idx"},   {24'd0, rec_idx},  32'd0);
      check({tag, "_we"},    {31'd0, rec_we},   32'd0);
      check({tag, "_wdata"}, {24'd0, rec_wdata}, 32'd0);
      check({tag, "_start"}, {31'd0, fb_start}, 32'd0);
      check({tag, "_dir"},   {31'd0, fb_dir},   32'd1);
      check({tag, "_addr"},  {24'd0, fb_addr},  {24'd0, BASE});
      check({tag, "_fbw"},   {24'd0, fb_wdata}, 32'hFF);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int start, k;
      RST = 1; save_req = 0; load_req = 0;
      spurious = 0; never_ready = 0; busy_polls = 2; prog_count = 0; fail_prog_n = 0;
      st_mode = 0; exp_conf = 0; exp_prog = 0; polls_left = 0; sr_err = 8'h00;
      for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
      record[0] = 8'h11; record[1] = 8'h22; record[2] = 8'h33; record[3] = 8'h44;
      repeat (3) @(posedge CLK_50MHZ);
      #1;
      check_reset_outputs("rst");
      RST = 0;
      repeat (2) @(posedge CLK_50MHZ);
      #1;

      // stray fb_done with nothing outstanding
      spurious = 1;
      repeat (4) @(posedge CLK_50MHZ);
      #1;
      check("stray_done_busy", {31'd0, busy}, 32'd0);
      check("stray_done_cnt", done_cnt, 0);

      // save {11,22,33,44} with 2 busy polls, then load it back (addresses wrap FE..01)
      run_save("save1", 2, 0, 0, 2'd0);
      for (int i = 0; i < 4; i++) check($sformatf("flash[%0d]", i), {24'd0, mem[BASE + 8'(i)]}, {24'd0, record[i]});
      run_load("load1");

      // program failure on the 2nd byte
      prog_count = 0; fail_prog_n = 2;
      run_save("progfail", 2, 2, 0, 2'd2);
      fail_prog_n = 0;

      // erase never completes
      never_ready = 1;
      run_save("timeout", 0, 0, 1, 2'd3);
      never_ready = 0;

      // simultaneous requests: save wins
      start = done_cnt;
      bus_log.delete(); we_log.delete(); busy_polls = 1;
      save_req = 1; load_req = 1; @(posedge CLK_50MHZ); #1; save_req = 0; load_req = 0;
      wait_done("both", start);
      check("both_code", {30'd0, last_code}, 32'd0);
      check("both_no_we", we_log.size(), 0);
      build_save(1, 0, 0);
      compare_log("both");

      // load_req mid-save is dropped
      start = done_cnt;
      bus_log.delete(); we_log.delete();
      save_req = 1; @(posedge CLK_50MHZ); #1; save_req = 0;
      repeat (30) @(posedge CLK_50MHZ);
      #1;
      load_req = 1; @(posedge CLK_50MHZ); #1; load_req = 0;
      wait_done("midload", start);
      repeat (60) @(posedge CLK_50MHZ);
      #1;
      check("midload_one_done", done_cnt, start + 1);
      check("midload_no_we", we_log.size(), 0);
      build_save(1, 0, 0);
      compare_log("midload");

      // randomized records and poll counts
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) record[i] = 8'($urandom);
         run_save($sformatf("rsave%0d", r), $urandom_range(0, 3), 0, 0, 2'd0);
         run_load($sformatf("rload%0d", r));
      end

      // reset during PROG_POLL
      start = done_cnt;
      bus_log.delete(); busy_polls = 3;
      save_req = 1; @(posedge CLK_50MHZ); #1; save_req = 0;
      k = 0;
      while (bus_log.size() < 9 && k < 2000) begin
         @(posedge CLK_50MHZ); #1; k++;
      end
      check("rst_mid_reached", {31'd0, (bus_log.size() >= 9)}, 32'd1);
      RST = 1;
      @(posedge CLK_50MHZ); #1;
      check_reset_outputs("rst_mid");
      @(posedge CLK_50MHZ); #1;
      RST = 0;
      repeat (20) @(posedge CLK_50MHZ);
      #1;
      check("rst_mid_no_done", done_cnt, start);
      check("rst_mid_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) record[i] = 8'($urandom);
      run_save("after_rst", 3, 0, 0, 2'd0);
      run_load("after_rst_load");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
